motion_update_rmw_ctrl: RTL
===========================

MOTION_UPDATE_RMW_CTRL -- requirements
Module: motion_update_rmw_ctrl

Interface
REQ-001 SHALL provide parameters, one per line:
- WIDTH, 16, position/delta word width
- DEPTH, 256, particle RAM words
- ADDR_WIDTH, 8, RAM address width
- NUM_PARTICLES, 256, particles per pass (1..DEPTH)
- RD_LAT, 2, RAM read latency in cycles (address registered plus output registered)
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock; all logic rising-edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, pulse: begin one update pass
- busy, out, 1, pass in progress
- done, out, 1, one-cycle pulse at pass end
- delta_valid, in, 1, displacement word available
- delta, in, WIDTH, signed displacement for current particle
- delta_ready, out, 1, block accepts delta this cycle
- ram_address, out, ADDR_WIDTH, to single-port RAM address
- ram_data, out, WIDTH, to RAM write data
- ram_wren, out, 1, to RAM write enable
- ram_q, in, WIDTH, from RAM registered read data
- pos_valid, out, 1, one-cycle pulse: updated position committed
- pos_out, out, WIDTH, updated position
- pos_idx, out, ADDR_WIDTH, index of pos_out
REQ-003 Clock SHALL be one clock named clock; reset SHALL be asynchronous, active-low, named rst_n.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, GET_DELTA, WR, FIN.
REQ-006 IDLE: start=1 -> RD_ISSUE with index=0 and busy=1 from the next cycle; start SHALL be ignored in all other states.
REQ-007 RD_ISSUE: exactly 1 cycle; ram_address=index, ram_wren=0; -> RD_WAIT.
REQ-008 RD_WAIT: exactly RD_LAT cycles (wait counter); ram_q SHALL be captured into the position register at the end of the last RD_WAIT cycle; -> GET_DELTA.
REQ-009 GET_DELTA: delta_ready=1; delta_ready SHALL be 0 in every other state; on delta_valid&&delta_ready, the sum register SHALL load pos+delta; -> WR. With delta_valid=0, the block SHALL hold indefinitely.
REQ-010 Arithmetic: two's-complement WIDTH-bit add; overflow SHALL wrap modulo 2^WIDTH (periodic box); no saturation.
REQ-011 WR: exactly 1 cycle; ram_wren=1, ram_address=index, ram_data=sum; pos_valid=1, pos_out=sum, pos_idx=index in the same cycle.
REQ-012 After WR: index==NUM_PARTICLES-1 -> FIN; otherwise index+1 -> RD_ISSUE.
REQ-013 FIN: 1 cycle, done=1, busy=0; -> IDLE. A start arriving in FIN SHALL be ignored.
REQ-014 ram_wren SHALL be 1 only in WR; RAM reads and writes SHALL never overlap (single-port).
REQ-015 Per-particle latency with delta_valid held 1 SHALL be 3+RD_LAT cycles (5 at default); full pass SHALL be NUM_PARTICLES*(3+RD_LAT)+1 cycles from the first busy cycle through the done cycle.
REQ-016 Index SHALL never exceed NUM_PARTICLES-1 and SHALL never wrap mid-pass.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state=IDLE and index, counters, busy, done, delta_ready, ram_wren, pos_valid, ram_address, ram_data, pos_out, and pos_idx to 0.
REQ-018 Reset mid-pass SHALL abort the pass with no further RAM writes. A write cycle cut by reset SHALL not be retried. After release, the block SHALL wait in IDLE for start.

Verification
REQ-019 Bench SHALL cover:
- RAM[0..3]=10,20,30,40, NUM_PARTICLES=4, deltas 1,2,3,4, delta_valid held 1 -> RAM=11,22,33,44; pos_valid x4; done at cycle 21 after start.
- RAM[0]=0x7FFF, delta=0x0001 -> RAM[0]=0x8000 (wrap); pos_out=0x8000.
- delta_valid withheld 10 cycles in GET_DELTA -> state held, ram_wren=0 throughout; sequence resumes on delta_valid.
- start pulsed while busy and in FIN -> no second pass; single done pulse.
- rst_n asserted during RD_WAIT of particle 2 -> all outputs 0 immediately; RAM[2..] unchanged; new start reruns from index 0.
- Protocol check across all runs: ram_wren never high outside WR; ram_address constant through RD_ISSUE..RD_WAIT of each particle.

Source files
------------

// File: rtl/motion_update_rmw_ctrl.sv
// Read-modify-write sequencer: for each particle, reads its position from a
// single-port RAM, adds a signed displacement and writes the wrapped sum back.
module motion_update_rmw_ctrl #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = 8,
  parameter int NUM_PARTICLES = 256,
  parameter int RD_LAT        = 2
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    delta_valid,
  input  logic signed [WIDTH-1:0] delta,
  output logic                    delta_ready,
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic [WIDTH-1:0]        ram_data,
  output logic                    ram_wren,
  input  logic [WIDTH-1:0]        ram_q,
  output logic                    pos_valid,
  output logic [WIDTH-1:0]        pos_out,
  output logic [ADDR_WIDTH-1:0]   pos_idx
);

  localparam int NP = (NUM_PARTICLES > DEPTH) ? DEPTH : NUM_PARTICLES;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NP - 1);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ISSUE  = 3'd1,
    RD_WAIT   = 3'd2,
    GET_DELTA = 3'd3,
    WR        = 3'd4,
    FIN       = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]   index, index_nxt;
  logic [CW-1:0]           wcnt, wcnt_nxt;
  logic signed [WIDTH-1:0] pos, pos_nxt;
  logic signed [WIDTH-1:0] sum, sum_nxt;

  logic                  busy_nxt, done_nxt, dready_nxt, wren_nxt, pvalid_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt, pidx_nxt;
  logic                  last_wait, accept;

  // Periodic box: the sum simply wraps modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] wrap_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] r;
    r = a + b;
    return r;
  endfunction

  assign last_wait = (wcnt == WAIT_LAST);
  assign accept    = delta_valid && delta_ready;

  // The sum register feeds both the RAM write port and the result port.
  assign ram_data = sum;
  assign pos_out  = sum;

  // State and datapath registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      wcnt        <= '0;
      pos         <= '0;
      sum         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      delta_ready <= 1'b0;
      ram_wren    <= 1'b0;
      pos_valid   <= 1'b0;
      ram_address <= '0;
      pos_idx     <= '0;
    end else begin
      state       <= state_nxt;
      index       <= index_nxt;
      wcnt        <= wcnt_nxt;
      pos         <= pos_nxt;
      sum         <= sum_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      delta_ready <= dready_nxt;
      ram_wren    <= wren_nxt;
      pos_valid   <= pvalid_nxt;
      ram_address <= addr_nxt;
      pos_idx     <= pidx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = RD_ISSUE;
      RD_ISSUE:  state_nxt = RD_WAIT;
      RD_WAIT:   if (last_wait) state_nxt = GET_DELTA;
      GET_DELTA: if (accept) state_nxt = WR;
      WR:        state_nxt = (index == LAST) ? FIN : RD_ISSUE;
      FIN:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    index_nxt = index;
    if (state == IDLE && start)
      index_nxt = '0;
    else if (state == WR && index != LAST)
      index_nxt = index + 1'b1;

    wcnt_nxt = (state == RD_WAIT && !last_wait) ? wcnt + 1'b1 : '0;
    pos_nxt  = (state == RD_WAIT && last_wait) ? $signed(ram_q) : pos;
    sum_nxt  = (state == GET_DELTA && accept) ? wrap_add(pos, delta) : sum;

    busy_nxt   = (state_nxt == RD_ISSUE) || (state_nxt == RD_WAIT) ||
                 (state_nxt == GET_DELTA) || (state_nxt == WR);
    done_nxt   = (state_nxt == FIN);
    dready_nxt = (state_nxt == GET_DELTA);
    wren_nxt   = (state_nxt == WR);
    pvalid_nxt = (state_nxt == WR);
    addr_nxt   = index_nxt;
    pidx_nxt   = (state_nxt == WR) ? index_nxt : pos_idx;
  end

endmodule
